// File: rtl/param_seq_detector_pkg.sv
// param_seq_detector_pkg: reset defaults, overlap mode encoding and cfg_len width helper
package param_seq_detector_pkg;
  localparam int DEFAULT_PATTERN = 'b1011;
  localparam int DEFAULT_LEN = 4;
  localparam logic DEFAULT_OVERLAP = 1'b1;
  localparam logic MODE_NONOVL = 1'b0;
  localparam logic MODE_OVL = 1'b1;
  function automatic int len_w(input int max_len);
    return $clog2(max_len + 1);
  endfunction
endpackage

// File: rtl/seq_match_counter.sv
// seq_match_counter: saturating match counter with synchronous clear
module seq_match_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] count
);
  // clear wins over increment; increment stops at all-ones
  always_ff @(posedge clk or negedge rst)
    if (!rst) count <= '0;
    else if (clr) count <= '0;
    else if (inc && count != '1) count <= count + 1'b1;
endmodule

// File: rtl/param_seq_detector.sv
// param_seq_detector: runtime-programmable Mealy serial pattern detector
module param_seq_detector
  import param_seq_detector_pkg::*;
#(
  parameter int MAX_LEN = 8,
  parameter int LEN_W = len_w(MAX_LEN),
  parameter int CNT_W = 16,
  parameter logic [MAX_LEN-1:0] DEFAULT_PATTERN = MAX_LEN'(param_seq_detector_pkg::DEFAULT_PATTERN),
  parameter int DEFAULT_LEN = param_seq_detector_pkg::DEFAULT_LEN,
  parameter logic DEFAULT_OVERLAP = param_seq_detector_pkg::DEFAULT_OVERLAP
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               din,
  input  logic               din_valid,
  input  logic               cfg_load,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cfg_overlap,
  input  logic               cnt_clr,
  output logic               dout,
  output logic [CNT_W-1:0]   match_count,
  output logic               cfg_err
);
  localparam int FILL_W = $clog2(MAX_LEN);
  logic [MAX_LEN-1:0] pat, mask, window;
  logic [LEN_W-1:0] len;
  logic ovl;
  logic [MAX_LEN-2:0] hist;
  logic [FILL_W-1:0] fill;
  logic accept, cfg_ok, hit;
  assign window = {hist, din};
  assign accept = din_valid & ~cfg_load;
  assign cfg_ok = cfg_len != '0 && int'(cfg_len) <= MAX_LEN;
  // thermometer mask keeping only the low len bits of the window
  always_comb begin
    mask = '0;
    for (int i = 0; i < MAX_LEN; i++) mask[i] = i < int'(len);
  end
  assign hit = accept && rst && int'(fill) >= int'(len) - 1 && ((window ^ pat) & mask) == '0;
  assign dout = hit;
  // config latch, bit history and fill tracking; a config strobe swallows din
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      pat <= DEFAULT_PATTERN;
      len <= LEN_W'(DEFAULT_LEN);
      ovl <= DEFAULT_OVERLAP;
      hist <= '0;
      fill <= '0;
      cfg_err <= 1'b0;
    end else if (cfg_load) begin
      cfg_err <= ~cfg_ok;
      if (cfg_ok) begin
        pat <= cfg_pattern;
        len <= cfg_len;
        ovl <= cfg_overlap;
        fill <= '0;
      end
    end else if (din_valid) begin
      hist <= window[MAX_LEN-2:0];
      fill <= (hit && ovl == MODE_NONOVL) ? '0 : (fill == FILL_W'(MAX_LEN - 1)) ? fill : fill + 1'b1;
    end
  seq_match_counter #(.CNT_W(CNT_W)) u_cnt (
    .clk(clk),
    .rst(rst),
    .inc(hit),
    .clr(cnt_clr),
    .count(match_count)
  );
endmodule

// File: tb/tb_param_seq_detector.sv
// tb_param_seq_detector: scoreboard bench with a queue-based reference model
module tb_param_seq_detector;
  localparam int MAX_LEN = 8;
  logic clk = 0, rst = 0, din = 0, din_valid = 0, cfg_load = 0, cfg_overlap = 0, cnt_clr = 0;
  logic [7:0] cfg_pattern = '0;
  logic [3:0] cfg_len = '0;
  logic dout, dout_s, cfg_err, cfg_err_s;
  logic [15:0] match_count;
  logic [1:0] match_count_s;
  int checks = 0, errors = 0;
  typedef struct {
    logic dout;
    int   cnt;
    int   cnt_s;
    logic err;
  } exp_t;
  exp_t sb[$];
  logic [7:0] m_pat;
  int m_len, m_cnt, m_cnt_s;
  logic m_ovl, m_err;
  logic m_q[$];

  always #5 clk = ~clk;

  param_seq_detector #(.MAX_LEN(MAX_LEN), .CNT_W(16)) u_dut (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .cfg_load(cfg_load),
    .cfg_pattern(cfg_pattern), .cfg_len(cfg_len), .cfg_overlap(cfg_overlap), .cnt_clr(cnt_clr),
    .dout(dout), .match_count(match_count), .cfg_err(cfg_err)
  );

  param_seq_detector #(.MAX_LEN(MAX_LEN), .CNT_W(2)) u_sat (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .cfg_load(cfg_load),
    .cfg_pattern(cfg_pattern), .cfg_len(cfg_len), .cfg_overlap(cfg_overlap), .cnt_clr(cnt_clr),
    .dout(dout_s), .match_count(match_count_s), .cfg_err(cfg_err_s)
  );

  task automatic m_reset();
    m_pat = 8'b1011;
    m_len = 4;
    m_ovl = 1'b1;
    m_q = {};
    m_cnt = 0;
    m_cnt_s = 0;
    m_err = 1'b0;
  endtask

  // match when the last len-1 accepted bits plus din spell the pattern, MSB first
  function automatic logic m_match(logic d);
    if (m_q.size() < m_len - 1) return 1'b0;
    for (int i = 0; i < m_len - 1; i++)
      if (m_q[m_q.size() - (m_len - 1) + i] != m_pat[m_len - 1 - i]) return 1'b0;
    return d == m_pat[0];
  endfunction

  task automatic cyc(logic d, logic v, logic ld, logic [7:0] p, logic [3:0] l, logic o, logic clr, logic r);
    exp_t e;
    logic hit;
    @(posedge clk);
    #1;
    rst = r; din = d; din_valid = v; cfg_load = ld;
    cfg_pattern = p; cfg_len = l; cfg_overlap = o; cnt_clr = clr;
    if (!r) m_reset();
    hit = r && v && !ld && m_match(d);
    e.dout = hit; e.cnt = m_cnt; e.cnt_s = m_cnt_s; e.err = m_err;
    sb.push_back(e);
    if (r) begin
      m_cnt = clr ? 0 : (hit && m_cnt < 65535) ? m_cnt + 1 : m_cnt;
      m_cnt_s = clr ? 0 : (hit && m_cnt_s < 3) ? m_cnt_s + 1 : m_cnt_s;
      if (ld) begin
        if (l >= 1 && l <= MAX_LEN) begin
          m_pat = p; m_len = int'(l); m_ovl = o; m_q = {}; m_err = 1'b0;
        end else m_err = 1'b1;
      end else if (v) begin
        if (hit && !m_ovl) m_q = {};
        else begin
          m_q.push_back(d);
          if (m_q.size() > MAX_LEN - 1) void'(m_q.pop_front());
        end
      end
    end
  endtask

  task automatic bitv(logic d); cyc(d, 1, 0, 0, 0, 0, 0, 1); endtask
  task automatic idle(); cyc(0, 0, 0, 0, 0, 0, 0, 1); endtask
  task automatic clear(); cyc(0, 0, 0, 0, 0, 0, 1, 1); endtask
  task automatic rst_cyc(); cyc(1, 1, 0, 0, 0, 0, 0, 0); endtask
  task automatic load(logic [7:0] p, logic [3:0] l, logic o); cyc(1, 1, 1, p, l, o, 0, 1); endtask
  task automatic send(logic [31:0] bits, int n);
    for (int i = n - 1; i >= 0; i--) bitv(bits[i]);
  endtask

  task automatic chk(string n, int a, int x);
    checks++;
    if (a != x) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", n, a, x);
    end
  endtask

  always @(negedge clk)
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      chk("dout", int'(dout), int'(e.dout));
      chk("dout_sat", int'(dout_s), int'(e.dout));
      chk("match_count", int'(match_count), e.cnt);
      chk("match_count_sat", int'(match_count_s), e.cnt_s);
      chk("cfg_err", int'(cfg_err), int'(e.err));
    end

  initial begin
    m_reset();
    rst_cyc();
    rst_cyc();
    send(32'b1011011, 7);
    idle();
    clear();
    load(8'b1011, 4, 0);
    send(32'b1011011, 7);
    idle();
    load(8'hFF, 8, 1);
    for (int i = 0; i < 10; i++) begin
      bitv(1);
      if (i % 3 == 1) idle();
    end
    load(8'h00, 0, 0);
    bitv(1);
    load(8'h01, 9, 0);
    bitv(1);
    bitv(0);
    load(8'h01, 1, 1);
    clear();
    bitv(1);
    cyc(1, 1, 0, 0, 0, 0, 1, 1);
    bitv(0);
    bitv(1);
    idle();
    load(8'b1011, 4, 1);
    send(32'b101, 3);
    rst_cyc();
    bitv(1);
    idle();
    for (int i = 0; i < 3000; i++) begin
      logic r, ld, v, clr;
      r = $urandom_range(0, 199) != 0;
      ld = $urandom_range(0, 39) == 0;
      v = $urandom_range(0, 3) != 0;
      clr = $urandom_range(0, 99) == 0;
      cyc(1'($urandom), v, ld, 8'($urandom),
          ($urandom_range(0, 5) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(1, 4)),
          1'($urandom), clr, r);
    end
    idle();
    repeat (3) @(posedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/param_seq_detector.md
# param_seq_detector

Parametrised Mealy serial-pattern detector, successor to the fixed-pattern overlapping detector. It matches a runtime-programmable bit pattern of up to MAX_LEN bits on a qualified serial input. Overlapping or non-overlapping detection is selectable at runtime, and a saturating match counter is included. It sits directly on a serial bitstream (line decoder, framing/sync search) and reports matches in the same cycle as the final pattern bit.

## Interface
Parameters:
- MAX_LEN, 8: maximum pattern length in bits (≥2)
- LEN_W, $clog2(MAX_LEN+1): width of cfg_len
- CNT_W, 16: match counter width
- DEFAULT_PATTERN, 'b1011: pattern after reset, right-aligned
- DEFAULT_LEN, 4: pattern length after reset
- DEFAULT_OVERLAP, 1: overlap mode after reset

Ports:
- clk  in  1  clock, rising-edge
- rst  in  1  reset, asynchronous, active-low
- din  in  1  serial data bit
- din_valid  in  1  din is sampled this cycle
- cfg_load  in  1  single-cycle strobe: latch cfg_pattern/cfg_len/cfg_overlap
- cfg_pattern  in  MAX_LEN  pattern; bit [len-1] is received first, bit [0] last
- cfg_len  in  LEN_W  pattern length, legal range 1..MAX_LEN
- cfg_overlap  in  1  1 = overlapping, 0 = non-overlapping
- cnt_clr  in  1  synchronous clear of match_count
- dout  out  1  Mealy match flag, combinational
- match_count  out  CNT_W  saturating count of matches
- cfg_err  out  1  last cfg_load was rejected

## Operation
- State: hist (MAX_LEN-1 bits; previously accepted bits, newest in LSB), fill (0..MAX_LEN-1; number of valid bits in hist, saturating), pat, len, ovl, match_count, cfg_err.
- Match condition: din_valid=1, cfg_load=0, rst deasserted, fill ≥ len-1, and {hist[len-2:0], din} == pat[len-1:0].
- len=1: the condition reduces to din==pat[0], with no history requirement.
- dout equals the match condition. It is forced to 0 while rst is low.
- Accepted bit (din_valid=1, cfg_load=0), at the clock edge:
  - hist shifts left and takes din into the LSB.
  - No match: fill increments, saturating at MAX_LEN-1.
  - Match with ovl=1: fill behaves as for no match.
  - Match with ovl=0: fill resets to 0, so the next match needs len fresh bits.
- din_valid=0: hist and fill hold, and dout=0.
- cfg_load=1, legal cfg_len:
  - Latch pat, len and ovl.
  - Clear fill (hist contents become don't-care).
  - cfg_err←0.
  - din is discarded that cycle.
- cfg_load=1, cfg_len=0 or cfg_len>MAX_LEN:
  - pat, len, ovl, hist and fill are all unchanged.
  - cfg_err←1.
  - din is still discarded.
- match_count:
  - +1 on each edge where dout=1.
  - Saturates at 2^CNT_W-1.
  - cnt_clr=1 forces 0, taking priority over a same-cycle match.
- Reset (async, at any time, including mid-pattern):
  - pat=DEFAULT_PATTERN, len=DEFAULT_LEN, ovl=DEFAULT_OVERLAP.
  - hist=0, fill=0.
  - match_count=0, cfg_err=0, dout=0.

## Timing
- dout has zero latency: it is valid in the same cycle as the last pattern bit, via a combinational path from din/din_valid to dout.
- match_count reflects a match one cycle after dout.
- A new configuration takes effect on the cycle after the cfg_load edge. The first match is possible no earlier than len accepted bits later.
- Reset release: the first bit is accepted on the first rising edge with rst high.
- Gaps in din_valid do not break a partial match; only accepted bits count.

## Structure
- Package param_seq_detector_pkg:
  - default parameter constants DEFAULT_PATTERN, DEFAULT_LEN and DEFAULT_OVERLAP;
  - a LEN_W helper function;
  - the mode encoding constants MODE_NONOVL=0 and MODE_OVL=1.
- Sub-module seq_match_counter (CNT_W parameter; inputs inc and clr; saturating; async active-low reset) holds match_count.
- The top level holds the config registers, hist/fill and the masked compare. The mask is generated from len.

## Test plan
- Reset defaults (1011, overlapping), stream 1,0,1,1,0,1,1 → dout=1 on bits 4 and 7; match_count=2.
- Load cfg_overlap=0, same pattern, same stream → dout=1 on bit 4 only; match_count=1.
- Load pattern 8'b11111111, len=8, overlap=1, then 10 ones with valid gaps inserted → dout=1 on accepted bits 8, 9, 10.
- Load cfg_len=0, then cfg_len=MAX_LEN+1 → cfg_err=1 each time and behaviour stays unchanged; a following legal load sets cfg_err=0.
- len=1 with pattern 1, stream 1,1,0,1 and cnt_clr asserted on the 2nd match cycle → dout=1 on bits 1, 2, 4; match_count ends at 1.
- Assert rst mid-pattern after bits 1,0,1, then send 1 → no match; outputs are 0 during reset.
- CNT_W=2, 5 matches → match_count saturates at 3.
